// File: rtl/i2s_audio_tx_if.sv
// i2s_audio_tx_if: stereo sample handshake between the mix stage and the I2S transmitter
interface i2s_audio_tx_if;
  logic signed [15:0] left;
  logic signed [15:0] right;
  logic               sample_valid;
  logic               sample_ready;
  modport master (output left, right, sample_valid, input sample_ready);
  modport slave  (input left, right, sample_valid, output sample_ready);
endinterface

// File: rtl/i2s_audio_tx.sv
// i2s_audio_tx: 16-bit stereo I2S transmitter with a one-deep sample buffer and a clk-derived bit clock
module i2s_audio_tx #(
  parameter int CLK_HZ_PAL  = 31500000,
  parameter int CLK_HZ_NTSC = 32940000,
  parameter int SAMPLE_RATE = 24000
) (
  input  logic           clk,
  input  logic           pll_lock,
  input  logic           ntscmode_i,
  input  logic           mute_i,
  i2s_audio_tx_if.slave  smp,
  output logic           frame_start_o,
  output logic           underrun_o,
  output logic           hp_bck_o,
  output logic           hp_ws_o,
  output logic           hp_din_o
);
  localparam logic [7:0] LIM_PAL  = 8'(CLK_HZ_PAL / (SAMPLE_RATE * 32) / 2 - 1);
  localparam logic [7:0] LIM_NTSC = 8'(CLK_HZ_NTSC / (SAMPLE_RATE * 32) / 2 - 1);
  logic [7:0]  cnt_q, cnt_d;
  logic [4:0]  slot_q, slot_d;
  logic [31:0] smp_q, smp_d, frame_q, frame_d;
  logic        bck_q, bck_d, ws_q, ws_d, din_q, din_d;
  logic        fs_q, fs_d, ur_q, ur_d, rdy_q, rdy_d, full_q, full_d;
  logic        wrap, fall, bound, acc;
  // frame holds {left, right}, so slot s is always bit 31-s
  always_comb begin
    wrap    = cnt_q >= (ntscmode_i ? LIM_NTSC : LIM_PAL);
    fall    = wrap && bck_q;
    bound   = fall && (slot_q == 5'd31);
    acc     = smp.sample_valid && rdy_q;
    cnt_d   = wrap ? 8'd0 : cnt_q + 8'd1;
    bck_d   = bck_q ^ wrap;
    slot_d  = fall ? slot_q + 5'd1 : slot_q;
    frame_d = !bound ? frame_q : mute_i ? 32'd0 : full_q ? smp_q : frame_q;
    full_d  = acc ? 1'b1 : bound ? 1'b0 : full_q;
    smp_d   = acc ? {smp.left, smp.right} : smp_q;
    rdy_d   = !full_d;
    ws_d    = fall ? slot_d[4] : ws_q;
    din_d   = fall ? frame_d[~slot_d] : din_q;
    fs_d    = bound;
    ur_d    = bound && !full_q;
  end
  always_ff @(posedge clk or negedge pll_lock) begin
    if (!pll_lock) begin
      cnt_q   <= '0;
      slot_q  <= '0;
      smp_q   <= '0;
      frame_q <= '0;
      bck_q   <= 1'b0;
      ws_q    <= 1'b0;
      din_q   <= 1'b0;
      fs_q    <= 1'b0;
      ur_q    <= 1'b0;
      rdy_q   <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      slot_q  <= slot_d;
      smp_q   <= smp_d;
      frame_q <= frame_d;
      bck_q   <= bck_d;
      ws_q    <= ws_d;
      din_q   <= din_d;
      fs_q    <= fs_d;
      ur_q    <= ur_d;
      rdy_q   <= rdy_d;
      full_q  <= full_d;
    end
  end
  assign smp.sample_ready = rdy_q;
  assign frame_start_o    = fs_q;
  assign underrun_o       = ur_q;
  assign hp_bck_o         = bck_q;
  assign hp_ws_o          = ws_q;
  assign hp_din_o         = din_q;
endmodule
